// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver. It oversamples SCL and SDA, matches a 7-bit address,
// ACKs the address and every data byte, and emits each received byte as a one-cycle strobe.
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAckAddr,
        StData,
        StAckData,
        StIgnore
    } state_e;

    state_e     state;
    logic [7:0] shift;
    logic [3:0] bit_cnt;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // Sync flops reset to 1 so an idle bus produces no edges after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= i2c_scl;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= i2c_sda_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0] shift_next;

    always_comb begin
        scl_rise   = scl_s2 & ~scl_h;
        scl_fall   = ~scl_s2 & scl_h;
        start_ev   = ~sda_s2 & sda_h & scl_s2 & scl_h;
        stop_ev    = sda_s2 & ~sda_h & scl_s2 & scl_h;
        shift_next = {shift[6:0], sda_s2};
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            shift      <= 8'h00;
            bit_cnt    <= 4'd0;
            i2c_sda_oe <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            if (start_ev) begin
                state      <= StAddr;
                bit_cnt    <= 4'd0;
                addr_match <= 1'b0;
                i2c_sda_oe <= 1'b0;
                start_det  <= 1'b1;
            end else if (stop_ev) begin
                state      <= StIdle;
                addr_match <= 1'b0;
                i2c_sda_oe <= 1'b0;
                stop_det   <= 1'b1;
            end else begin
                if (scl_rise && state != StIdle) begin
                    shift   <= shift_next;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    StAddr: begin
                        if (scl_rise && bit_cnt == 4'd7) begin
                            if (shift_next[7:1] == TARGET_ADDR && !shift_next[0]) begin
                                state <= StAckAddr;
                            end else begin
                                state <= StIgnore;
                            end
                        end
                    end
                    // The first SCL fall after bit 8 starts the ACK, the next one ends it.
                    StAckAddr, StAckData: begin
                        if (scl_fall) begin
                            if (!i2c_sda_oe) begin
                                i2c_sda_oe <= 1'b1;
                                addr_match <= 1'b1;
                            end else begin
                                i2c_sda_oe <= 1'b0;
                                bit_cnt    <= 4'd0;
                                state      <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (scl_rise && bit_cnt == 4'd7) begin
                            rx_data  <= shift_next;
                            rx_valid <= 1'b1;
                            state    <= StAckData;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- I2C target (slave) receiver; the far end of the team's I2C write initiator.
- Oversamples the external SCL/SDA lines on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit device address, ACKs it, and delivers each received write data byte to core logic as a one-cycle strobe.
- Write-only: read requests are NACKed. Sits between the board I2C pins (open-drain) and the core register logic.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit device address this block responds to.

Ports:
- clk  input  1  system clock (100 MHz nominal).
- reset  input  1  asynchronous, active-high reset.
- i2c_scl  input  1  bus SCL; asynchronous to clk.
- i2c_sda_in  input  1  bus SDA as read from the pad; asynchronous to clk.
- i2c_sda_oe  output  1  1 = pull SDA low (open-drain enable); 0 = release.
- rx_data  output  8  last received data byte; held until the next byte completes.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.
- addr_match  output  1  high from the ACKed address phase until the next START/STOP.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, active-high), all values immediate:
  - Outputs: i2c_sda_oe=0, rx_data=8'h00, rx_valid=0, start_det=0, stop_det=0, addr_match=0, busy=0.
  - Internals: state=IDLE, shift register=0, bit counter=0.
  - Sync flops reset to 1 (idle bus).
- Synchronisation:
  - SCL and SDA each pass through a 2-flop synchroniser, then a 1-flop history register.
  - Edges are derived from synchroniser stage 2 versus history.
  - All actions are registered on the clk edge after edge detection, so pin-to-action latency is 3–4 clk cycles.
  - Supported input: SCL high and low phases of at least 8 clk cycles each.
- Bus events (evaluated on synced signals; take priority over bit handling in the same cycle):
  - START: SDA falling while SCL high. From any state: state=ADDR, bit counter=0, addr_match=0, release SDA, start_det pulse.
  - STOP: SDA rising while SCL high. From any state: state=IDLE, addr_match=0, release SDA, stop_det pulse.
- Bit sampling: on each SCL rising edge, shift SDA into the LSB of the shift register (MSB first on the wire) and increment the bit counter.
- State machine:
  - IDLE: wait for START.
  - ADDR: after the 8th rising edge, shift[7:1] is the address and shift[0] is R/W.
    - If address == TARGET_ADDR and R/W=0: next state ACK_ADDR.
    - Otherwise: next state IGNORE (no ACK driven).
  - ACK_ADDR:
    - On the SCL falling edge after bit 8: i2c_sda_oe=1, addr_match=1.
    - On the next SCL falling edge: i2c_sda_oe=0, bit counter=0, state=DATA.
  - DATA: after the 8th rising edge, rx_data=shift and rx_valid pulses for exactly 1 cycle; state=ACK_DATA.
  - ACK_DATA: drive ACK exactly as in ACK_ADDR, then return to DATA. There is no limit on bytes per transaction.
  - IGNORE: i2c_sda_oe held 0; wait for START or STOP.
- SCL edges seen in IDLE are ignored.
- i2c_sda_oe changes only after a synced SCL falling edge, a START, a STOP, or reset. It never changes while SCL is high.
- A START or STOP arriving mid-byte discards the partial byte; rx_valid does not pulse.
- Reset mid-transfer releases SDA immediately. After reset the block ignores the bus until the next START.
- rx_valid, start_det and stop_det are never asserted in the same cycle as one another.

Test Plan:
- START, 0xA0 (addr 0x50, W), 0xAA, STOP at SCL = 100 kHz -> i2c_sda_oe=1 during both ACK clocks; rx_valid pulses once with rx_data=8'hAA; start_det and stop_det each pulse once; busy=0 after STOP.
- START, 0xA2 (addr 0x51, W), 0x55, STOP -> i2c_sda_oe stays 0 throughout; no rx_valid; addr_match stays 0; stop_det pulses.
- START, 0xA1 (addr 0x50, R) -> no ACK; state=IGNORE until STOP; no rx_valid.
- START, 0xA0, 0x12, 0x34, repeated START, 0xA0, 0x56, STOP -> three rx_valid pulses with values 0x12, 0x34, 0x56; start_det pulses twice; addr_match drops at the repeated START and returns at its ACK.
- START, 0xA0, 4 bits of 0xF0, then reset asserted for 3 cycles -> i2c_sda_oe=0 and all outputs at reset values immediately. A subsequent full START, 0xA0, 0x3C, STOP -> rx_data=0x3C.
- START, 0xA0, 5 bits, then STOP -> no rx_valid; rx_data keeps its previous value; i2c_sda_oe=0; busy=0.
